// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word read per cycle and hands
// PC-tagged instructions to decode. Optional macro FETCH_ALIGN_CHECK_EN faults on misaligned redirects.
module fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = 32'h80020000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_busy,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              insn_valid,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_req_valid;
  logic [ADDR_W-1:0]   r_req_pc;
  logic [DATA_W-1:0]   r_insn;
  logic [ADDR_W-1:0]   r_insn_pc;
  logic                r_insn_valid;
  logic                r_fault;
  logic                w_misaligned;
  logic [ADDR_W-1:0]   w_redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_pc = redirect_pc;
`else
  // Low address bits are silently dropped; the fault path is unreachable.
  assign w_misaligned  = 1'b0;
  assign w_redirect_pc = redirect_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  w_state_next = StRun;
      StRun:   if (redirect && w_misaligned) w_state_next = StFault;
      StFault: w_state_next = StFault;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    mem_enable = 1'b0;
    if (r_state == StRun) begin
      mem_enable = !(stall && r_insn_valid) && !redirect;
    end
  end

  assign mem_address     = r_pc;
  assign mem_access_size = 2'b00;
  assign mem_rw          = 1'b1;
  assign insn            = r_insn;
  assign insn_pc         = r_insn_pc;
  assign insn_valid      = r_insn_valid;
  assign fetch_fault     = r_fault;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= START_ADDR;
      r_req_valid  <= 1'b0;
      r_req_pc     <= '0;
      r_insn       <= '0;
      r_insn_pc    <= '0;
      r_insn_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else if (r_state == StRun) begin
      if (redirect) begin
        r_req_valid  <= 1'b0;
        r_insn_valid <= 1'b0;
        if (w_misaligned) begin
          r_fault <= 1'b1;
        end else begin
          r_pc <= w_redirect_pc;
        end
      end else if (stall && r_insn_valid) begin
        // Decode holds the current insn; the in-flight word is dropped and re-fetched later.
        if (r_req_valid) begin
          r_pc        <= r_req_pc;
          r_req_valid <= 1'b0;
        end
      end else if (mem_busy && r_req_valid) begin
        r_pc         <= r_req_pc;
        r_req_valid  <= 1'b0;
        r_insn_valid <= 1'b0;
      end else begin
        if (r_req_valid) begin
          r_insn       <= mem_data;
          r_insn_pc    <= r_req_pc;
          r_insn_valid <= 1'b1;
        end else begin
          r_insn_valid <= 1'b0;
        end
        r_req_valid <= 1'b1;
        r_req_pc    <= r_pc;
        r_pc        <= r_pc + ADDR_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected (insn, pc) pairs, a monitor
// pops one whenever decode accepts an instruction. Directed checks cover reset, stall, redirect.
module tb_fetch_unit;

  localparam logic [31:0] S = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic [31:0] mem_data = '0;
  logic        mem_busy;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        fetch_fault;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] q_insn[$];
  logic [31:0] q_pc[$];

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .mem_address     (mem_address),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_enable      (mem_enable),
    .mem_data        (mem_data),
    .mem_busy        (mem_busy),
    .insn            (insn),
    .insn_pc         (insn_pc),
    .insn_valid      (insn_valid),
    .fetch_fault     (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      S:         return 32'h11111111;
      S + 4:     return 32'h22222222;
      S + 8:     return 32'h33333333;
      S + 12:    return 32'h44444444;
      default:   return a ^ 32'h5A5A0000;
    endcase
  endfunction

  // Synchronous-read memory: data registered at the end of the cycle the address is presented.
  always @(posedge clock) begin
    if (mem_enable) mem_data <= word(mem_address);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] a);
    q_insn.push_back(word(a));
    q_pc.push_back(a);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && insn_valid && !stall) begin
      if (q_pc.size() == 0) begin
        chk("unexpected_insn_pc", insn_pc, 32'hxxxxxxxx);
      end else begin
        chk("sb_insn", insn, q_insn.pop_front());
        chk("sb_pc", insn_pc, q_pc.pop_front());
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, insn_valid}, 32'd0);
    chk({tag, "_insn"}, insn, 32'd0);
    chk({tag, "_insn_pc"}, insn_pc, 32'd0);
    chk({tag, "_en"}, {31'd0, mem_enable}, 32'd0);
    chk({tag, "_addr"}, mem_address, S);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_busy = 1'b0;
    step(); step();
    chk_reset_state("rst");
    chk("rst_size", {30'd0, mem_access_size}, 32'd0);
    chk("rst_rw", {31'd0, mem_rw}, 32'd1);
    push(S); push(S + 4);
    reset = 1'b0;
    step();                                   // E1: IDLE -> RUN
    chk("e1_en", {31'd0, mem_enable}, 32'd1);
    chk("e1_addr", mem_address, S);
    step();                                   // E2: issue
    chk("e2_addr", mem_address, S + 4);
    chk("e2_valid", {31'd0, insn_valid}, 32'd0);
    step();                                   // E3: first capture
    chk("e3_valid", {31'd0, insn_valid}, 32'd1);
    chk("e3_pc", insn_pc, S);
    step();                                   // E4
    stall = 1'b1;
    repeat (2) begin
      step();
      chk("stall_insn", insn, 32'h22222222);
      chk("stall_en", {31'd0, mem_enable}, 32'd0);
    end
    step();                                   // E7
    chk("stall_pc", insn_pc, S + 4);
    push(S + 8); push(S + 12);
    stall = 1'b0;
    step();                                   // E8: replay bubble
    chk("bubble_valid", {31'd0, insn_valid}, 32'd0);
    step();                                   // E9
    chk("after_stall_pc", insn_pc, S + 8);
    step();                                   // E10
    redirect = 1'b1; redirect_pc = S + 32'h40;
    #1;
    chk("redir_en", {31'd0, mem_enable}, 32'd0);
    push(S + 32'h40); push(S + 32'h44);
    step();                                   // E11: redirect edge
    redirect = 1'b0;
    chk("redir_valid", {31'd0, insn_valid}, 32'd0);
    chk("redir_addr", mem_address, S + 32'h40);
    step();
    step();                                   // E13
    chk("redir_first_pc", insn_pc, S + 32'h40);
    step();                                   // E14
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    push(32'hFFFFFFFC); push(32'h00000000);
    step();
    redirect = 1'b0;
    chk("wrap_addr0", mem_address, 32'hFFFFFFFC);
    step();
    chk("wrap_addr1", mem_address, 32'h00000000);
    step(); step();                           // E18
    redirect = 1'b1; redirect_pc = S + 32'h42;
`ifdef FETCH_ALIGN_CHECK_EN
    step();
    redirect = 1'b0;
    repeat (3) begin
      chk("align_fault", {31'd0, fetch_fault}, 32'd1);
      chk("align_en", {31'd0, mem_enable}, 32'd0);
      chk("align_valid", {31'd0, insn_valid}, 32'd0);
      step();
    end
`else
    push(S + 32'h40); push(S + 32'h44);
    step();
    redirect = 1'b0;
    chk("align_addr", mem_address, S + 32'h40);
    chk("align_fault", {31'd0, fetch_fault}, 32'd0);
    step(); step(); step(); step();
`endif
    // Reset in the middle of a stall.
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(S);
    step(); step(); step();                   // E3: 0x11 valid
    step();
    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk_reset_state("midrst");
    reset = 1'b0; stall = 1'b0;
    // One-cycle busy pulse forces a replay of the outstanding address.
    push(S); push(S + 4); push(S + 8); push(S + 12);
    step(); step(); step();                   // E3: 0x11 valid, S+4 outstanding
    mem_busy = 1'b1;
    step();
    mem_busy = 1'b0;
    chk("busy_valid", {31'd0, insn_valid}, 32'd0);
    chk("busy_replay_addr", mem_address, S + 4);
    step();
    chk("busy_bubble", {31'd0, insn_valid}, 32'd0);
    chk("busy_next_addr", mem_address, S + 8);
    step(); step(); step();                   // 0x22, 0x33, 0x44
    step();
    stall = 1'b1;
    step();
    chk("queue_drained", q_pc.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
